// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_unit
// Brief    : Single-cycle ALU plus iterative radix-2 RV32M multiply/divide,
//            valid/ready handshakes on operands and results.
// Revision : 1.0 - initial release
// ============================================================================

module alu_muldiv_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq,
  output logic                  busy
);

  localparam int c_CNT_W = $clog2(DATA_WIDTH);
  localparam logic [c_CNT_W-1:0]    c_CNT_LAST = {c_CNT_W{1'b1}};
  localparam logic [c_CNT_W-1:0]    c_CNT_ONE  = {{(c_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] c_MIN      = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [4:0] c_OP_ADD    = 5'd0;
  localparam logic [4:0] c_OP_SUB    = 5'd1;
  localparam logic [4:0] c_OP_AND    = 5'd2;
  localparam logic [4:0] c_OP_OR     = 5'd3;
  localparam logic [4:0] c_OP_XOR    = 5'd4;
  localparam logic [4:0] c_OP_SLL    = 5'd5;
  localparam logic [4:0] c_OP_SRL    = 5'd6;
  localparam logic [4:0] c_OP_SRA    = 5'd7;
  localparam logic [4:0] c_OP_SLT    = 5'd8;
  localparam logic [4:0] c_OP_SLTU   = 5'd9;
  localparam logic [4:0] c_OP_MUL    = 5'd10;
  localparam logic [4:0] c_OP_MULH   = 5'd11;
  localparam logic [4:0] c_OP_MULHSU = 5'd12;
  localparam logic [4:0] c_OP_MULHU  = 5'd13;
  localparam logic [4:0] c_OP_DIV    = 5'd14;
  localparam logic [4:0] c_OP_DIVU   = 5'd15;
  localparam logic [4:0] c_OP_REM    = 5'd16;
  localparam logic [4:0] c_OP_REMU   = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  state_t                    w_dispatch;
  logic [4:0]                r_op;
  logic [2*DATA_WIDTH-1:0]   r_acc;
  logic [DATA_WIDTH-1:0]     r_opnd;
  logic                      r_neg_res;
  logic                      r_neg_rem;
  logic [c_CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]     r_result;
  logic                      r_eq;

  logic                      w_accept;
  logic                      w_is_mul;
  logic                      w_is_div;
  logic                      w_div_zero;
  logic                      w_div_ovf;
  logic                      w_div_special;
  logic                      w_sa;
  logic                      w_sb;
  logic [DATA_WIDTH-1:0]     w_mag_a;
  logic [DATA_WIDTH-1:0]     w_mag_b;
  logic [SHAMT_WIDTH-1:0]    w_shamt;
  logic [DATA_WIDTH-1:0]     w_alu;
  logic [DATA_WIDTH-1:0]     w_special;
  logic                      w_cnt_last;
  logic [DATA_WIDTH:0]       w_mul_sum;
  logic [2*DATA_WIDTH-1:0]   w_mul_next;
  logic [DATA_WIDTH:0]       w_div_hi;
  logic                      w_div_ge;
  logic [DATA_WIDTH-1:0]     w_div_diff;
  logic [2*DATA_WIDTH-1:0]   w_div_next;
  logic [2*DATA_WIDTH-1:0]   w_acc_next;
  logic [2*DATA_WIDTH-1:0]   w_prod;
  logic [DATA_WIDTH-1:0]     w_final;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
  assign result    = r_result;
  assign eq        = r_eq;

  assign w_accept   = in_valid && in_ready && !flush;
  assign w_is_mul   = (op >= c_OP_MUL) && (op <= c_OP_MULHU);
  assign w_is_div   = (op >= c_OP_DIV) && (op <= c_OP_REMU);
  assign w_cnt_last = (r_cnt == c_CNT_LAST);

  assign w_div_zero    = (op_b == '0);
  assign w_div_ovf     = ((op == c_OP_DIV) || (op == c_OP_REM)) && (op_a == c_MIN) && (op_b == '1);
  assign w_div_special = w_is_div && (w_div_zero || w_div_ovf);

  // Engines run on magnitudes; the signs are re-applied when the last step lands.
  assign w_sa    = op_a[DATA_WIDTH-1] &&
                   ((op == c_OP_MULH) || (op == c_OP_MULHSU) || (op == c_OP_DIV) || (op == c_OP_REM));
  assign w_sb    = op_b[DATA_WIDTH-1] &&
                   ((op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM));
  assign w_mag_a = w_sa ? -op_a : op_a;
  assign w_mag_b = w_sb ? -op_b : op_b;
  assign w_shamt = op_b[SHAMT_WIDTH-1:0];

  always_comb begin
    w_alu = '0;
    case (op)
      c_OP_ADD:  w_alu = op_a + op_b;
      c_OP_SUB:  w_alu = op_a - op_b;
      c_OP_AND:  w_alu = op_a & op_b;
      c_OP_OR:   w_alu = op_a | op_b;
      c_OP_XOR:  w_alu = op_a ^ op_b;
      c_OP_SLL:  w_alu = op_a << w_shamt;
      c_OP_SRL:  w_alu = op_a >> w_shamt;
      c_OP_SRA:  w_alu = $unsigned($signed(op_a) >>> w_shamt);
      c_OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      c_OP_SLTU: w_alu = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
      default:   w_alu = '0;
    endcase
  end

  always_comb begin
    w_special = '0;
    if (w_div_zero) begin
      w_special = ((op == c_OP_DIV) || (op == c_OP_DIVU)) ? '1 : op_a;
    end else begin
      w_special = (op == c_OP_DIV) ? c_MIN : '0;
    end
  end

  // Multiply: accumulate into the high half, shift the whole product right.
  assign w_mul_sum  = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};

  // Divide: remainder in the high half, quotient bits shift in at the bottom.
  assign w_div_hi   = r_acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
  assign w_div_ge   = (w_div_hi >= {1'b0, r_opnd});
  assign w_div_diff = w_div_hi[DATA_WIDTH-1:0] - r_opnd;
  assign w_div_next = w_div_ge ? {w_div_diff, r_acc[DATA_WIDTH-2:0], 1'b1}
                               : {r_acc[2*DATA_WIDTH-2:0], 1'b0};

  assign w_acc_next = (r_state == S_MUL) ? w_mul_next : w_div_next;
  assign w_prod     = r_neg_res ? -w_acc_next : w_acc_next;

  always_comb begin
    w_final = '0;
    case (r_op)
      c_OP_MUL:                            w_final = w_prod[DATA_WIDTH-1:0];
      c_OP_MULH, c_OP_MULHSU, c_OP_MULHU:  w_final = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      c_OP_DIV, c_OP_DIVU:
        w_final = r_neg_res ? -w_acc_next[DATA_WIDTH-1:0] : w_acc_next[DATA_WIDTH-1:0];
      c_OP_REM, c_OP_REMU:
        w_final = r_neg_rem ? -w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH]
                            : w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
      default:                             w_final = '0;
    endcase
  end

  always_comb begin
    w_dispatch = S_DONE;
    if (w_is_mul) begin
      w_dispatch = S_MUL;
    end else if (w_is_div && !w_div_special) begin
      w_dispatch = S_DIV;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:        if (w_accept) w_state_next = w_dispatch;
      S_MUL, S_DIV:  if (w_cnt_last) w_state_next = S_DONE;
      S_DONE: begin
        if (w_accept) begin
          w_state_next = w_dispatch;
        end else if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default:       w_state_next = S_IDLE;
    endcase
    if (flush) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_eq      <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op      <= op;
      r_eq      <= (op_a == op_b);
      r_cnt     <= '0;
      r_neg_res <= w_sa ^ w_sb;
      r_neg_rem <= w_sa;
      if (w_is_mul) begin
        r_acc  <= {{DATA_WIDTH{1'b0}}, w_mag_b};
        r_opnd <= w_mag_a;
      end else begin
        r_acc  <= {{DATA_WIDTH{1'b0}}, w_mag_a};
        r_opnd <= w_mag_b;
      end
      if (w_div_special) begin
        r_result <= w_special;
      end else if (!w_is_mul && !w_is_div) begin
        r_result <= w_alu;
      end
    end else if (busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + c_CNT_ONE;
      if (w_cnt_last) begin
        r_result <= w_final;
        r_cnt    <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_unit
// Brief    : Scoreboard bench for alu_muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_alu_muldiv_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_VAL = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [4:0]   op = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         eq;
  logic         busy;

  alu_muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .eq        (eq),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] res;
    logic         eq;
    int unsigned  issue;
    int unsigned  lat;
  } item_t;

  item_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    in_reset = 1'b1;
  int    rdy_mode = 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [4:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int                sa;
    int                sb;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic [63:0]        p;
    logic               ovf;
    sa   = $signed(a);
    sb   = $signed(b);
    sa64 = sa;
    sb64 = sb;
    ovf  = (a == MIN_VAL) && (b == '1);
    case (f)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return $unsigned(sa >>> b[4:0]);
      5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  return (a < b) ? 32'd1 : 32'd0;
      5'd10: begin p = sa64 * sb64; return p[31:0]; end
      5'd11: begin p = sa64 * sb64; return p[63:32]; end
      5'd12: begin p = sa64 * $signed({32'b0, b}); return p[63:32]; end
      5'd13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      5'd14: return (b == 0) ? '1 : (ovf ? MIN_VAL : $unsigned(sa / sb));
      5'd15: return (b == 0) ? '1 : a / b;
      5'd16: return (b == 0) ? a : (ovf ? 32'd0 : $unsigned(sa % sb));
      5'd17: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int unsigned ref_latency(input logic [4:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    if (f >= 5'd10 && f <= 5'd13) return W + 1;
    if (f >= 5'd14 && f <= 5'd17) begin
      if (b == 0) return 1;
      if ((f == 5'd14 || f == 5'd16) && a == MIN_VAL && b == '1) return 1;
      return W + 1;
    end
    return 1;
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return MIN_VAL;
      3:       return 32'($urandom_range(0, 16));
      4:       return -32'($urandom_range(1, 16));
      default: return $urandom();
    endcase
  endfunction

  // Driver tasks are entered and left one time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [4:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    item_t it;
    bit    done;
    done     = 1'b0;
    in_valid = 1'b1;
    op       = f;
    op_a     = a;
    op_b     = b;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        it.op    = f;
        it.res   = ref_result(f, a, b);
        it.eq    = (a == b);
        it.issue = cyc;
        it.lat   = ref_latency(f, a, b);
        sb_q.push_back(it);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: op %0d never accepted, in_ready stayed %b", f, in_ready);
    end
  endtask

  // Presents a legal op alongside flush; it must not be accepted.
  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b1;
    op       = 5'd0;
    op_a     = $urandom();
    op_b     = $urandom();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: the front of the queue determines what the outputs must show.
  always @(negedge clk) begin
    if (!in_reset) begin
      bit started;
      bit exp_valid;
      bit exp_busy;
      started   = (sb_q.size() > 0) && (cyc > sb_q[0].issue);
      exp_valid = started && (cyc >= sb_q[0].issue + sb_q[0].lat);
      exp_busy  = started && (sb_q[0].lat > 1) && (cyc <= sb_q[0].issue + W);
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("in_ready", {31'b0, in_ready}, {31'b0, (!started || (exp_valid && out_ready))});
      if (exp_valid) begin
        check($sformatf("result op%0d", sb_q[0].op), result, sb_q[0].res);
        check($sformatf("eq op%0d", sb_q[0].op), {31'b0, eq}, {31'b0, sb_q[0].eq});
        if (out_ready) void'(sb_q.pop_front());
      end
      if (flush) sb_q.delete();
    end
  end

  initial begin
    #1;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset eq", {31'b0, eq}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_reset = 1'b0;

    rdy_mode = 1;
    issue(5'd0, 32'd5, 32'd7);
    issue(5'd1, 32'd3, 32'd5);
    issue(5'd0, 32'd9, 32'd9);
    issue(5'd10, 32'hFFFF_FFFD, 32'd7);
    issue(5'd11, 32'hFFFF_FFFD, 32'd7);
    issue(5'd13, 32'hFFFF_FFFD, 32'd7);
    issue(5'd14, 32'd7, 32'd0);
    issue(5'd16, 32'd7, 32'd0);
    issue(5'd15, 32'd7, 32'd0);
    issue(5'd14, MIN_VAL, 32'hFFFF_FFFF);
    issue(5'd16, MIN_VAL, 32'hFFFF_FFFF);
    issue(5'd14, 32'hFFFF_FFF9, 32'd2);
    issue(5'd16, 32'hFFFF_FFF9, 32'd2);
    issue(5'd20, 32'd1, 32'd1);

    // Backpressure then a back-to-back handoff.
    idle(2);
    rdy_mode = 0;
    issue(5'd0, 32'd21, 32'd21);
    idle(5);
    rdy_mode = 1;
    issue(5'd5, 32'd1, 32'd4);
    idle(2);

    // Flush part-way through an unsigned divide.
    issue(5'd15, 32'd1000, 32'd7);
    idle(9);
    do_flush();
    idle(2);

    // Asynchronous reset in the middle of a multiply.
    issue(5'd10, 32'd123, 32'd456);
    idle(5);
    #1;
    in_reset = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("midreset out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset in_ready", {31'b0, in_ready}, 32'd1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic [4:0] f;
      if (i % 50 == 0) rdy_mode = $urandom_range(1, 2);
      f = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(10, 17)) : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) < 3) begin
        do_flush();
      end else begin
        issue(f, rand_opnd(), rand_opnd());
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    rdy_mode = 1;
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) idle(1);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d results still outstanding, expected 0", sb_q.size());
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
